serpent_lt_pipe: RTL and testbench

Parametrised, pipelined Serpent linear-transform unit for the serpent_xts datapath. It applies the forward LT (encrypt), or the inverse LT (decrypt, when compiled in), to a 128-bit state, with round-based bypass. It uses a valid/ready handshake, a configurable register depth and a sideband tag. It sits between the S-box layer and the round-key XOR in the round engine.

---
 rtl/serpent_pkg.sv | 42 ++++
 rtl/serpent_lt_half.sv | 74 +++++++
 rtl/serpent_lt_pipe.sv | 157 +++++++++++++++
 tb/tb_serpent_lt_pipe.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serpent_pkg.sv
// Shared constants, mode encoding and rotate helpers for the Serpent
// linear-transform datapath.
//
// Contents:
//   SERPENT_BLOCK_W / SERPENT_WORD_W / SERPENT_ROUNDS - block geometry
//   LT_ROT_* / LT_SHL_*                              - LT rotate and shift amounts
//   lt_mode_e                                         - LT_FWD (0) / LT_INV (1)
//   rol32 / ror32                                     - 32-bit rotates
package serpent_pkg;

  localparam int SERPENT_BLOCK_W = 128;
  localparam int SERPENT_WORD_W  = 32;
  localparam int SERPENT_ROUNDS  = 32;

  // Rotate amounts in the order they appear in the forward transform.
  localparam int LT_ROT_A = 13;
  localparam int LT_ROT_B = 3;
  localparam int LT_ROT_C = 1;
  localparam int LT_ROT_D = 7;
  localparam int LT_ROT_E = 5;
  localparam int LT_ROT_F = 22;

  // Logical left shifts; bits shifted out are dropped.
  localparam int LT_SHL_A = 3;
  localparam int LT_SHL_B = 7;

  typedef enum logic {
    LT_FWD = 1'b0,
    LT_INV = 1'b1
  } lt_mode_e;

  function automatic logic [SERPENT_WORD_W-1:0] rol32(input logic [SERPENT_WORD_W-1:0] x,
                                                      input int unsigned n);
    rol32 = (x << n) | (x >> (SERPENT_WORD_W - n));
  endfunction

  function automatic logic [SERPENT_WORD_W-1:0] ror32(input logic [SERPENT_WORD_W-1:0] x,
                                                      input int unsigned n);
    ror32 = (x >> n) | (x << (SERPENT_WORD_W - n));
  endfunction

endpackage

// File: rtl/serpent_lt_half.sv
// Combinational half of the Serpent linear transform.
//
// Half 0 covers the first three step lines of the selected direction, half 1
// the remaining two, so chaining half 0 then half 1 gives the full transform
// in either direction.
//
// Ports:
//   i_state  128-bit state, X0=[127:96] .. X3=[31:0]
//   i_half   0 = first part, 1 = second part
//   i_mode   LT_FWD / LT_INV
//   o_state  transformed state
//
// Build option: SERPENT_LT_INV_EN compiles in the inverse transform; without
// it i_mode is ignored and only the forward transform exists.
module serpent_lt_half
  import serpent_pkg::*;
(
  input  logic [SERPENT_BLOCK_W-1:0] i_state,
  input  logic                       i_half,
  input  logic                       i_mode,
  output logic [SERPENT_BLOCK_W-1:0] o_state
);

  logic [SERPENT_WORD_W-1:0] a0, a1, a2, a3;
  logic [SERPENT_WORD_W-1:0] f0, f1, f2, f3;

  assign {a0, a1, a2, a3} = i_state;

  always_comb begin
    f0 = a0;
    f1 = a1;
    f2 = a2;
    f3 = a3;
    if (!i_half) begin
      f0 = rol32(a0, LT_ROT_A);
      f2 = rol32(a2, LT_ROT_B);
      f1 = rol32(a1 ^ f0 ^ f2, LT_ROT_C);
      f3 = rol32(a3 ^ f2 ^ (f0 << LT_SHL_A), LT_ROT_D);
    end else begin
      f0 = rol32(a0 ^ a1 ^ a3, LT_ROT_E);
      f2 = rol32(a2 ^ a3 ^ (a1 << LT_SHL_B), LT_ROT_F);
    end
  end

`ifdef SERPENT_LT_INV_EN
  logic [SERPENT_WORD_W-1:0] r0, r1, r2, r3;

  always_comb begin
    r0 = a0;
    r1 = a1;
    r2 = a2;
    r3 = a3;
    if (!i_half) begin
      // X1/X3 are untouched until the last line, so the XOR undo uses them raw.
      r2 = ror32(a2, LT_ROT_F) ^ a3 ^ (a1 << LT_SHL_B);
      r0 = ror32(a0, LT_ROT_E) ^ a1 ^ a3;
      r3 = ror32(a3, LT_ROT_D);
      r1 = ror32(a1, LT_ROT_C);
    end else begin
      r3 = a3 ^ a2 ^ (a0 << LT_SHL_A);
      r1 = a1 ^ a0 ^ a2;
      r2 = ror32(a2, LT_ROT_B);
      r0 = ror32(a0, LT_ROT_A);
    end
  end

  assign o_state = (i_mode == LT_INV) ? {r0, r1, r2, r3} : {f0, f1, f2, f3};
`else
  logic unused_mode;
  assign unused_mode = i_mode;
  assign o_state     = {f0, f1, f2, f3};
`endif

endmodule

// File: rtl/serpent_lt_pipe.sv
// Pipelined Serpent linear-transform unit with round bypass and sideband tag.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid/o_ready       input handshake; i_data, i_round, i_mode, i_tag
//   o_valid/i_ready       output handshake; o_data, o_tag, o_bypassed
//
// Handshake: a word moves on a cycle where valid and ready are both high.
// A producer holds valid and its payload stable until accepted; o_ready is
// combinational from i_ready and never depends on i_valid.
//
// PIPE_STAGES=1 computes the whole transform before one register; 2 splits it
// after the first three step lines. Build option SERPENT_LT_INV_EN enables the
// inverse transform selected by i_mode=1.
module serpent_lt_pipe
  import serpent_pkg::*;
#(
  parameter int PIPE_STAGES  = 1,
  parameter int BYPASS_ROUND = 31,
  parameter int ROUND_W      = 6,
  parameter int TAG_W        = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [SERPENT_BLOCK_W-1:0] i_data,
  input  logic [ROUND_W-1:0]         i_round,
  input  logic                       i_mode,
  input  logic [TAG_W-1:0]           i_tag,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [SERPENT_BLOCK_W-1:0] o_data,
  output logic [TAG_W-1:0]           o_tag,
  output logic                       o_bypassed
);

  if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_depth
    $error("serpent_lt_pipe: PIPE_STAGES must be 1 or 2");
  end
  if ((1 << ROUND_W) < SERPENT_ROUNDS) begin : g_bad_round_w
    $error("serpent_lt_pipe: ROUND_W too narrow for a round index");
  end

  logic mode_in;
  logic byp_in;

`ifdef SERPENT_LT_INV_EN
  assign mode_in = i_mode;
`else
  logic unused_mode;
  assign unused_mode = i_mode;
  assign mode_in     = LT_FWD;
`endif

  assign byp_in = (i_round == ROUND_W'(BYPASS_ROUND));

  // Per-stage registers and the values presented to each stage.
  logic [PIPE_STAGES-1:0]     v_q, v_d, mode_q, mode_d, byp_q, byp_d, ld;
  logic [SERPENT_BLOCK_W-1:0] data_q [PIPE_STAGES];
  logic [SERPENT_BLOCK_W-1:0] data_d [PIPE_STAGES];
  logic [TAG_W-1:0]           tag_q  [PIPE_STAGES];
  logic [TAG_W-1:0]           tag_d  [PIPE_STAGES];

  logic [PIPE_STAGES-1:0]     in_v, in_mode, in_byp;
  logic [SERPENT_BLOCK_W-1:0] in_data [PIPE_STAGES];
  logic [TAG_W-1:0]           in_tag  [PIPE_STAGES];

  logic [SERPENT_BLOCK_W-1:0] h0_out, h1_in, h1_out;
  logic                       h1_mode;

  // Half 1 follows half 0 directly in the single-stage build and reads the
  // stage-0 register (with its latched mode) in the two-stage build.
  assign h1_in   = (PIPE_STAGES == 1) ? h0_out  : data_q[0];
  assign h1_mode = (PIPE_STAGES == 1) ? mode_in : mode_q[0];

  serpent_lt_half u_half0 (
    .i_state (i_data),
    .i_half  (1'b0),
    .i_mode  (mode_in),
    .o_state (h0_out)
  );

  serpent_lt_half u_half1 (
    .i_state (h1_in),
    .i_half  (1'b1),
    .i_mode  (h1_mode),
    .o_state (h1_out)
  );

  assign in_v[0]    = i_valid;
  assign in_mode[0] = mode_in;
  assign in_byp[0]  = byp_in;
  assign in_tag[0]  = i_tag;

  if (PIPE_STAGES == 2) begin : g_two
    assign ld[1]      = !v_q[1] || i_ready;
    assign ld[0]      = !v_q[0] || ld[1];
    assign in_data[0] = byp_in ? i_data : h0_out;
    assign in_v[1]    = v_q[0];
    assign in_mode[1] = mode_q[0];
    assign in_byp[1]  = byp_q[0];
    assign in_tag[1]  = tag_q[0];
    assign in_data[1] = byp_q[0] ? data_q[0] : h1_out;
  end else begin : g_one
    assign ld[0]      = !v_q[0] || i_ready;
    assign in_data[0] = byp_in ? i_data : h1_out;
  end

  // A loading stage takes the upstream valid bit; payload only moves with a
  // valid word so idle stages keep their last contents.
  always_comb begin
    v_d    = v_q;
    mode_d = mode_q;
    byp_d  = byp_q;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      data_d[k] = data_q[k];
      tag_d[k]  = tag_q[k];
      if (ld[k]) begin
        v_d[k] = in_v[k];
        if (in_v[k]) begin
          data_d[k] = in_data[k];
          tag_d[k]  = in_tag[k];
          mode_d[k] = in_mode[k];
          byp_d[k]  = in_byp[k];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_q    <= '0;
      mode_q <= '0;
      byp_q  <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      v_q    <= v_d;
      mode_q <= mode_d;
      byp_q  <= byp_d;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        data_q[k] <= data_d[k];
        tag_q[k]  <= tag_d[k];
      end
    end
  end

  assign o_ready    = ld[0];
  assign o_valid    = v_q[PIPE_STAGES-1];
  assign o_data     = data_q[PIPE_STAGES-1];
  assign o_tag      = tag_q[PIPE_STAGES-1];
  assign o_bypassed = byp_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_serpent_lt_pipe.sv
// Testbench for serpent_lt_pipe: a 1-stage and a 2-stage instance run side by
// side on the same words. Each instance only sees i_valid while the other is
// ready, so both accept exactly the same word stream. A negedge scoreboard
// compares every output against a reference model and checks stall stability
// and o_ready against the modelled occupancy.
module tb_serpent_lt_pipe;

  localparam int TAG_W   = 8;
  localparam int ROUND_W = 6;
  localparam int BYP     = 31;
  localparam int EW      = 128 + TAG_W + 1;

`ifdef SERPENT_LT_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam logic [127:0] V_UNIT = {32'h1, 32'h0, 32'h0, 32'h0};
  localparam logic [127:0] V_FWD  = {32'h100C0000, 32'h00004000, 32'h00002800, 32'h00800000};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               drv_valid;
  logic [127:0]       drv_data;
  logic [ROUND_W-1:0] drv_round;
  logic               drv_mode;
  logic [TAG_W-1:0]   drv_tag;
  logic               rdy;

  logic               valid1, valid2, o_ready1, o_ready2, o_valid1, o_valid2;
  logic [127:0]       o_data1, o_data2;
  logic [TAG_W-1:0]   o_tag1, o_tag2;
  logic               o_byp1, o_byp2;

  assign valid1 = drv_valid && o_ready2;
  assign valid2 = drv_valid && o_ready1;

  serpent_lt_pipe #(.PIPE_STAGES(1), .BYPASS_ROUND(BYP), .ROUND_W(ROUND_W), .TAG_W(TAG_W)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid1), .o_ready(o_ready1), .i_data(drv_data),
    .i_round(drv_round), .i_mode(drv_mode), .i_tag(drv_tag), .o_valid(o_valid1),
    .i_ready(rdy), .o_data(o_data1), .o_tag(o_tag1), .o_bypassed(o_byp1)
  );

  serpent_lt_pipe #(.PIPE_STAGES(2), .BYPASS_ROUND(BYP), .ROUND_W(ROUND_W), .TAG_W(TAG_W)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid2), .o_ready(o_ready2), .i_data(drv_data),
    .i_round(drv_round), .i_mode(drv_mode), .i_tag(drv_tag), .o_valid(o_valid2),
    .i_ready(rdy), .o_data(o_data2), .o_tag(o_tag2), .o_bypassed(o_byp2)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [127:0] lt_fwd(input logic [127:0] s);
    logic [31:0] x0, x1, x2, x3;
    {x0, x1, x2, x3} = s;
    x0 = rl(x0, 13);            x2 = rl(x2, 3);
    x1 = x1 ^ x0 ^ x2;          x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rl(x1, 1);             x3 = rl(x3, 7);
    x0 = x0 ^ x1 ^ x3;          x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rl(x0, 5);             x2 = rl(x2, 22);
    return {x0, x1, x2, x3};
  endfunction

  function automatic logic [127:0] lt_inv(input logic [127:0] s);
    logic [31:0] x0, x1, x2, x3;
    {x0, x1, x2, x3} = s;
    x2 = rr(x2, 22);            x0 = rr(x0, 5);
    x2 = x2 ^ x3 ^ (x1 << 7);   x0 = x0 ^ x1 ^ x3;
    x3 = rr(x3, 7);             x1 = rr(x1, 1);
    x3 = x3 ^ x2 ^ (x0 << 3);   x1 = x1 ^ x0 ^ x2;
    x2 = rr(x2, 3);             x0 = rr(x0, 13);
    return {x0, x1, x2, x3};
  endfunction

  function automatic logic [EW-1:0] model(input logic [127:0] d, input logic [ROUND_W-1:0] r,
                                          input logic m, input logic [TAG_W-1:0] t);
    logic [127:0] res;
    logic         b;
    b = (r == ROUND_W'(BYP));
    if (b)                res = d;
    else if (INV_EN && m) res = lt_inv(d);
    else                  res = lt_fwd(d);
    return {res, t, b};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];
  bit            sb_en = 1'b0;
  bit            hold1 = 1'b0, hold2 = 1'b0;
  logic [EW-1:0] held1, held2, obs1, obs2, sb_e;

  always @(negedge clk) begin
    if (sb_en) begin
      obs1 = {o_data1, o_tag1, o_byp1};
      obs2 = {o_data2, o_tag2, o_byp2};
      // Ready drops only when every stage is occupied and downstream stalls.
      n_checks++;
      if (o_ready1 !== (rdy || exp_q1.size() < 1)) begin
        n_errors++;
        $display("FAIL sb_ready1: got %b need %b (occ %0d)", o_ready1, rdy || exp_q1.size() < 1, exp_q1.size());
      end
      n_checks++;
      if (o_ready2 !== (rdy || exp_q2.size() < 2)) begin
        n_errors++;
        $display("FAIL sb_ready2: got %b need %b (occ %0d)", o_ready2, rdy || exp_q2.size() < 2, exp_q2.size());
      end
      if (hold1) begin
        n_checks++;
        if (o_valid1 !== 1'b1 || obs1 !== held1) begin
          n_errors++;
          $display("FAIL sb_stall1: got v=%b %h need v=1 %h", o_valid1, obs1, held1);
        end
      end
      if (hold2) begin
        n_checks++;
        if (o_valid2 !== 1'b1 || obs2 !== held2) begin
          n_errors++;
          $display("FAIL sb_stall2: got v=%b %h need v=1 %h", o_valid2, obs2, held2);
        end
      end
      if (o_valid1 && rdy) begin
        n_checks++;
        if (exp_q1.size() == 0) begin
          n_errors++;
          $display("FAIL sb_extra1: got %h need nothing", obs1);
        end else begin
          sb_e = exp_q1.pop_front();
          if (obs1 !== sb_e) begin
            n_errors++;
            $display("FAIL sb_data1: got %h need %h", obs1, sb_e);
          end
        end
      end
      if (o_valid2 && rdy) begin
        n_checks++;
        if (exp_q2.size() == 0) begin
          n_errors++;
          $display("FAIL sb_extra2: got %h need nothing", obs2);
        end else begin
          sb_e = exp_q2.pop_front();
          if (obs2 !== sb_e) begin
            n_errors++;
            $display("FAIL sb_data2: got %h need %h", obs2, sb_e);
          end
        end
      end
      hold1 = o_valid1 && !rdy;
      hold2 = o_valid2 && !rdy;
      held1 = obs1;
      held2 = obs2;
      if (drv_valid && o_ready1 && o_ready2) begin
        sb_e = model(drv_data, drv_round, drv_mode, drv_tag);
        exp_q1.push_back(sb_e);
        exp_q2.push_back(sb_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one word until both instances take it; returns #1 after that edge.
  task automatic send_word(input logic [127:0] d, input logic [ROUND_W-1:0] r,
                           input logic m, input logic [TAG_W-1:0] t);
    bit acc;
    acc       = 1'b0;
    drv_valid = 1'b1;
    drv_data  = d;
    drv_round = r;
    drv_mode  = m;
    drv_tag   = t;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = o_ready1 && o_ready2;
      @(posedge clk);
      #1;
    end
    drv_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got no accept need accept within 200 cycles");
    end
  endtask

  // Sends one word into empty pipes (i_ready high) and captures each result
  // with its latency in cycles after the accepting edge.
  task automatic run_one(input logic [127:0] d, input logic [ROUND_W-1:0] r, input logic m,
                         input logic [TAG_W-1:0] t,
                         output logic [127:0] d1, output logic [127:0] d2,
                         output logic b1, output logic b2, output int lat1, output int lat2);
    d1 = '0; d2 = '0; b1 = 1'b0; b2 = 1'b0; lat1 = -1; lat2 = -1;
    send_word(d, r, m, t);
    for (int c = 1; c <= 8 && (lat1 < 0 || lat2 < 0); c++) begin
      if (lat1 < 0 && o_valid1) begin lat1 = c; d1 = o_data1; b1 = o_byp1; end
      if (lat2 < 0 && o_valid2) begin lat2 = c; d2 = o_data2; b2 = o_byp2; end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if (o_valid1 !== 1'b0 || o_data1 !== '0 || o_tag1 !== '0 || o_byp1 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_out1: got v=%b d=%h t=%h b=%b need all zero", o_valid1, o_data1, o_tag1, o_byp1);
    end
    n_checks++;
    if (o_valid2 !== 1'b0 || o_data2 !== '0 || o_tag2 !== '0 || o_byp2 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_out2: got v=%b d=%h t=%h b=%b need all zero", o_valid2, o_data2, o_tag2, o_byp2);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (o_ready1 !== 1'b1 || o_ready2 !== 1'b1 || o_valid1 !== 1'b0 || o_valid2 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ready: got rdy=%b%b v=%b%b need rdy=11 v=00", o_ready1, o_ready2, o_valid1, o_valid2);
    end
  endtask

  task automatic test_forward_vector();
    logic [127:0] d1, d2;
    logic b1, b2;
    int l1, l2;
    run_one(V_UNIT, 6'd0, 1'b0, 8'h11, d1, d2, b1, b2, l1, l2);
    n_checks++;
    if (d1 !== V_FWD || b1 !== 1'b0) begin
      n_errors++;
      $display("FAIL fwd_vec1: got %h b=%b need %h b=0", d1, b1, V_FWD);
    end
    n_checks++;
    if (d2 !== V_FWD || b2 !== 1'b0) begin
      n_errors++;
      $display("FAIL fwd_vec2: got %h b=%b need %h b=0", d2, b2, V_FWD);
    end
    n_checks++;
    if (l1 != 1) begin n_errors++; $display("FAIL fwd_lat1: got %0d need 1", l1); end
    n_checks++;
    if (l2 != 2) begin n_errors++; $display("FAIL fwd_lat2: got %0d need 2", l2); end
  endtask

  task automatic test_bypass();
    logic [127:0] d1, d2;
    logic b1, b2;
    int l1, l2;
    for (int m = 0; m < 2; m++) begin
      run_one(V_UNIT, 6'(BYP), m[0], 8'h20 + 8'(m), d1, d2, b1, b2, l1, l2);
      n_checks++;
      if (d1 !== V_UNIT || b1 !== 1'b1) begin
        n_errors++;
        $display("FAIL bypass1 mode=%0d: got %h b=%b need %h b=1", m, d1, b1, V_UNIT);
      end
      n_checks++;
      if (d2 !== V_UNIT || b2 !== 1'b1) begin
        n_errors++;
        $display("FAIL bypass2 mode=%0d: got %h b=%b need %h b=1", m, d2, b2, V_UNIT);
      end
    end
  endtask

  task automatic test_inverse();
    logic [127:0] d1, d2, z1, z2, x;
    logic b1, b2;
    int l1, l2;
`ifdef SERPENT_LT_INV_EN
    run_one(V_FWD, 6'd0, 1'b1, 8'h30, d1, d2, b1, b2, l1, l2);
    n_checks++;
    if (d1 !== V_UNIT || d2 !== V_UNIT) begin
      n_errors++;
      $display("FAIL inv_vec: got %h / %h need %h", d1, d2, V_UNIT);
    end
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_one(x, 6'($urandom_range(0, 30)), 1'b0, 8'(i), d1, d2, b1, b2, l1, l2);
      n_checks++;
      if (d1 !== lt_fwd(x) || d2 !== lt_fwd(x)) begin
        n_errors++;
        $display("FAIL trip_fwd %0d: got %h / %h need %h", i, d1, d2, lt_fwd(x));
      end
      run_one(d1, 6'($urandom_range(0, 30)), 1'b1, 8'(i), z1, z2, b1, b2, l1, l2);
      n_checks++;
      if (z1 !== x || z2 !== x) begin
        n_errors++;
        $display("FAIL trip_inv %0d: got %h / %h need %h", i, z1, z2, x);
      end
    end
`else
    x = V_UNIT;
    run_one(x, 6'd0, 1'b1, 8'h30, d1, d2, b1, b2, l1, l2);
    n_checks++;
    if (d1 !== V_FWD || d2 !== V_FWD) begin
      n_errors++;
      $display("FAIL mode_ignored: got %h / %h need %h", d1, d2, V_FWD);
    end
    z1 = '0; z2 = '0;
`endif
  endtask

  task automatic test_back_to_back();
    bit ev1, ev2;
    rdy = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      if (c < 10) begin
        drv_valid = 1'b1;
        drv_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        drv_round = 6'($urandom_range(0, 31));
        drv_mode  = 1'($urandom_range(0, 1));
        drv_tag   = 8'(c);
      end else begin
        drv_valid = 1'b0;
      end
      ev1 = (c >= 1 && c <= 10);
      ev2 = (c >= 2 && c <= 11);
      n_checks++;
      if (o_valid1 !== ev1 || (ev1 && o_tag1 !== 8'(c - 1))) begin
        n_errors++;
        $display("FAIL b2b_1 c=%0d: got v=%b tag=%0d need v=%b tag=%0d", c, o_valid1, o_tag1, ev1, c - 1);
      end
      n_checks++;
      if (o_valid2 !== ev2 || (ev2 && o_tag2 !== 8'(c - 2))) begin
        n_errors++;
        $display("FAIL b2b_2 c=%0d: got v=%b tag=%0d need v=%b tag=%0d", c, o_valid2, o_tag2, ev2, c - 2);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stall();
    int  sent;
    bit  acc;
    sent      = 0;
    drv_valid = 1'b1;
    drv_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    drv_round = 6'($urandom_range(0, 31));
    drv_mode  = 1'($urandom_range(0, 1));
    drv_tag   = 8'($urandom());
    rdy       = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 4000 && sent < 300; cyc++) begin
      @(negedge clk);
      acc = drv_valid && o_ready1 && o_ready2;
      @(posedge clk);
      #1;
      rdy = 1'($urandom_range(0, 1));
      if (acc) begin
        sent++;
        if (sent < 300) begin
          drv_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
          drv_round = 6'($urandom_range(0, 31));
          drv_mode  = 1'($urandom_range(0, 1));
          drv_tag   = 8'($urandom());
        end else begin
          drv_valid = 1'b0;
        end
      end
    end
    drv_valid = 1'b0;
    rdy       = 1'b1;
    for (int i = 0; i < 50 && (exp_q1.size() != 0 || exp_q2.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (sent != 300 || exp_q1.size() != 0 || exp_q2.size() != 0) begin
      n_errors++;
      $display("FAIL stall_drain: got sent=%0d left=%0d/%0d need 300 and 0/0", sent, exp_q1.size(), exp_q2.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] d1, d2, x;
    logic [EW-1:0] e;
    logic b1, b2;
    int l1, l2;
    rdy = 1'b1;
    send_word(128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004, 6'd3, 1'b0, 8'hA1);
    send_word(128'h5A5A_0001_5A5A_0002_5A5A_0003_5A5A_0004, 6'd4, 1'b0, 8'hA2);
    sb_en = 1'b0;
    n_checks++;
    if (o_valid2 !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_inflight: got v2=%b need 1", o_valid2);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (o_valid1 !== 1'b0 || o_valid2 !== 1'b0 || o_data1 !== '0 || o_data2 !== '0 ||
        o_tag1 !== '0 || o_tag2 !== '0 || o_byp1 !== 1'b0 || o_byp2 !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset: got v=%b%b d=%h/%h need zeros", o_valid1, o_valid2, o_data1, o_data2);
    end
    rst = 1'b0;
    n_checks++;
    if (o_ready1 !== 1'b1 || o_ready2 !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_ready: got %b%b need 11", o_ready1, o_ready2);
    end
    exp_q1.delete();
    exp_q2.delete();
    hold1 = 1'b0;
    hold2 = 1'b0;
    sb_en = 1'b1;
    x = {$urandom(), $urandom(), $urandom(), $urandom()};
    e = model(x, 6'd7, 1'b0, 8'h5C);
    run_one(x, 6'd7, 1'b0, 8'h5C, d1, d2, b1, b2, l1, l2);
    n_checks++;
    if (d1 !== e[EW-1 -: 128] || d2 !== e[EW-1 -: 128] || l1 != 1 || l2 != 2) begin
      n_errors++;
      $display("FAIL mid_after: got %h / %h lat %0d/%0d need %h lat 1/2", d1, d2, l1, l2, e[EW-1 -: 128]);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst       = 1'b1;
    drv_valid = 1'b0;
    drv_data  = '0;
    drv_round = '0;
    drv_mode  = 1'b0;
    drv_tag   = '0;
    rdy       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    sb_en = 1'b1;
    test_forward_vector();
    test_bypass();
    test_inverse();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got no finish need finish before 500us");
    $fatal(1, "watchdog expired");
  end

endmodule
